// File: rtl/pipeline_debug_ctrl_pkg.sv
// Shared definitions for the pipeline debug controller: command bytes,
// the HALT instruction word, FSM state encodings and the dump item count.
// Optional feature macro: PIPELINE_DEBUG_CYCLE_COUNT_EN (adds one dump item).
package pipeline_debug_ctrl_pkg;

    // Host command bytes, accepted only while idle
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

    // Writing this word terminates a program load
    localparam logic [31:0] HALT_WORD = 32'h0000_003F;

    // Main controller states; byte transmission lives in the serializer
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_WR,
        ST_RUN,
        ST_STEP,
        ST_SET_ADDR,
        ST_SETTLE,
        ST_LATCH,
        ST_DUMP_WAIT
    } state_t;

    // Serializer states
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT
    } tx_state_t;

    // Number of 32-bit items in one dump: PC, registers, memory, optional cycle count
    function automatic int unsigned dump_items(input int unsigned n_regs,
                                               input int unsigned n_mem,
                                               input bit          cyc_en);
        return 32'd1 + n_regs + n_mem + (cyc_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/pipeline_debug_ctrl_word_tx.sv
// Word-to-byte serializer: latches a word on start, sends it MSB first as
// bytes over a start/done UART transmit handshake, then pulses done.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   word, start         word to send, one-cycle start pulse (accepted when idle)
//   tx_data, tx_start   byte and one-cycle start pulse to the UART transmitter
//   tx_done             one-cycle pulse from the transmitter, byte sent
//   done                one-cycle pulse after the last byte's tx_done
module word_tx_serializer
    import pipeline_debug_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SZ = 32,
    parameter int unsigned BYTE_SZ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_SZ-1:0] word,
    input  logic               start,
    output logic [BYTE_SZ-1:0] tx_data,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               done
);

    localparam int unsigned BPW    = WORD_SZ / BYTE_SZ;
    localparam int unsigned BCNT_W = $clog2(BPW);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 1);

    tx_state_t          state;
    logic [WORD_SZ-1:0] shift;
    logic [BCNT_W-1:0]  byte_cnt;

    // tx_data is only updated in TX_START, so it holds through the wait for tx_done
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            shift    <= '0;
            byte_cnt <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        shift    <= word;
                        byte_cnt <= '0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    tx_data  <= shift[WORD_SZ-1 -: BYTE_SZ];
                    tx_start <= 1'b1;
                    state    <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (byte_cnt == LAST_BYTE) begin
                            done  <= 1'b1;
                            state <= TX_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                            shift    <= shift << BYTE_SZ;
                            state    <= TX_START;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Host-side driver for the pipeline load/run/debug interface. Assembles UART
// bytes into instruction words and writes them, runs or single-steps the
// pipeline, then dumps PC, registers and data memory back over the UART.
// Optional feature macro: PIPELINE_DEBUG_CYCLE_COUNT_EN -- appends a saturating
// 32-bit count of enabled cycles in the last RUN/STEP to the dump.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_rx_data, i_rx_valid      received byte and its one-cycle valid
//   o_tx_data, o_tx_start      byte and start pulse to the UART transmitter
//   i_tx_done                  transmitter byte-sent pulse
//   o_write, o_instruction     instruction-memory write strobe and word
//   o_enable, i_halt           pipeline run enable, pipeline halted
//   o_debug_addr               debug read address for registers/memory
//   i_pc, i_reg, i_mem         debug read data
//   o_busy                     high whenever not idle
module pipeline_debug_ctrl
    import pipeline_debug_ctrl_pkg::*;
#(
    parameter int unsigned INST_SZ   = 32,
    parameter int unsigned BYTE_SZ   = 8,
    parameter int unsigned REG_SZ    = 5,
    parameter int unsigned N_REGS    = 32,
    parameter int unsigned N_MEM     = 32,
    parameter int unsigned MAX_INSTR = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [BYTE_SZ-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_enable,
    input  logic               i_halt,
    output logic [REG_SZ-1:0]  o_debug_addr,
    input  logic [INST_SZ-1:0] i_pc,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic [INST_SZ-1:0] i_mem,
    output logic               o_busy
);

    localparam int unsigned BPW    = INST_SZ / BYTE_SZ;
    localparam int unsigned BCNT_W = $clog2(BPW);
    localparam int unsigned WCNT_W = $clog2(MAX_INSTR + 1);
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif
    localparam int unsigned N_ITEMS = dump_items(N_REGS, N_MEM, CYC_EN);
    localparam int unsigned ITEM_W  = $clog2(N_ITEMS);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(MAX_INSTR - 1);
    localparam logic [ITEM_W-1:0] REG_FIRST = ITEM_W'(1);
    localparam logic [ITEM_W-1:0] REG_LAST  = ITEM_W'(N_REGS);
    localparam logic [ITEM_W-1:0] MEM_FIRST = ITEM_W'(N_REGS + 1);
    localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(N_ITEMS - 1);

    state_t                     state;
    logic [BCNT_W-1:0]          byte_cnt;
    logic [WCNT_W-1:0]          word_cnt;
    logic [INST_SZ-BYTE_SZ-1:0] load_shift;  // first three bytes of the word in flight
    logic [ITEM_W-1:0]          item;
    logic [INST_SZ-1:0]         tx_word;
    logic                       ser_start;
    logic                       ser_done;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
    logic [31:0]                cyc_cnt;
`endif

    // Main controller
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            load_shift    <= '0;
            item          <= '0;
            tx_word       <= '0;
            ser_start     <= 1'b0;
            o_write       <= 1'b0;
            o_instruction <= '0;
            o_enable      <= 1'b0;
            o_debug_addr  <= '0;
            o_busy        <= 1'b0;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
            cyc_cnt       <= '0;
`endif
        end else begin
            o_write   <= 1'b0;
            ser_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                byte_cnt <= '0;
                                word_cnt <= '0;
                                o_busy   <= 1'b1;
                                state    <= ST_LOAD;
                            end
                            CMD_RUN: begin
                                o_enable <= 1'b1;
                                o_busy   <= 1'b1;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
                                cyc_cnt  <= '0;
`endif
                                state    <= ST_RUN;
                            end
                            CMD_STEP: begin
                                o_enable <= 1'b1;
                                o_busy   <= 1'b1;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
                                cyc_cnt  <= '0;
`endif
                                state    <= ST_STEP;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    // MSB-first assembly; the output word changes only on the write
                    if (i_rx_valid) begin
                        if (byte_cnt == LAST_BYTE) begin
                            o_instruction <= {load_shift, i_rx_data};
                            o_write       <= 1'b1;
                            byte_cnt      <= '0;
                            state         <= ST_LOAD_WR;
                        end else begin
                            load_shift <= {load_shift[INST_SZ-2*BYTE_SZ-1:0], i_rx_data};
                            byte_cnt   <= byte_cnt + BCNT_W'(1);
                        end
                    end
                end
                ST_LOAD_WR: begin
                    if (o_instruction == HALT_WORD || word_cnt == LAST_WORD) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        word_cnt <= word_cnt + WCNT_W'(1);
                        state    <= ST_LOAD;
                    end
                end
                ST_RUN: begin
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
                    if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
`endif
                    if (i_halt) begin
                        o_enable <= 1'b0;
                        item     <= '0;
                        state    <= ST_SET_ADDR;
                    end
                end
                ST_STEP: begin
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
                    if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
`endif
                    o_enable <= 1'b0;
                    item     <= '0;
                    state    <= ST_SET_ADDR;
                end
                ST_SET_ADDR: begin
                    // Item 0 is the PC; address value is irrelevant there
                    if (item == '0) begin
                        o_debug_addr <= '0;
                    end else if (item <= REG_LAST) begin
                        o_debug_addr <= REG_SZ'(item - REG_FIRST);
                    end else begin
                        o_debug_addr <= REG_SZ'(item - MEM_FIRST);
                    end
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (item == '0) begin
                        tx_word <= i_pc;
                    end else if (item <= REG_LAST) begin
                        tx_word <= i_reg;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
                    end else if (item == LAST_ITEM) begin
                        tx_word <= INST_SZ'(cyc_cnt);
`endif
                    end else begin
                        tx_word <= i_mem;
                    end
                    ser_start <= 1'b1;
                    state     <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (ser_done) begin
                        if (item == LAST_ITEM) begin
                            o_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            item  <= item + ITEM_W'(1);
                            state <= ST_SET_ADDR;
                        end
                    end
                end
                default: begin
                    o_enable <= 1'b0;
                    o_busy   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    word_tx_serializer #(
        .WORD_SZ (INST_SZ),
        .BYTE_SZ (BYTE_SZ)
    ) u_word_tx (
        .clk      (i_clk),
        .reset    (i_reset),
        .word     (tx_word),
        .start    (ser_start),
        .tx_data  (o_tx_data),
        .tx_start (o_tx_start),
        .tx_done  (i_tx_done),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed testbench for pipeline_debug_ctrl: program load, reset mid-load,
// run/step with dump readback, slow transmitter handshake.
// Honors PIPELINE_DEBUG_CYCLE_COUNT_EN (expects the extra 4-byte count).
module tb_pipeline_debug_ctrl;

`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
    localparam int DUMP_BYTES = 264;
`else
    localparam int DUMP_BYTES = 260;
`endif
    localparam logic [31:0] PC_VAL = 32'h0000_001C;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_write;
    logic [31:0] o_instruction;
    logic        o_enable;
    logic        i_halt;
    logic [4:0]  o_debug_addr;
    logic [31:0] i_pc;
    logic [31:0] i_reg;
    logic [31:0] i_mem;
    logic        o_busy;

    always #5 clk = ~clk;

    pipeline_debug_ctrl dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .i_tx_done     (i_tx_done),
        .o_write       (o_write),
        .o_instruction (o_instruction),
        .o_enable      (o_enable),
        .i_halt        (i_halt),
        .o_debug_addr  (o_debug_addr),
        .i_pc          (i_pc),
        .i_reg         (i_reg),
        .i_mem         (i_mem),
        .o_busy        (o_busy)
    );

    // Pipeline debug-read model
    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return (a == 5'd10) ? 32'h0000_0002 : {8'h11, 3'b000, a, 16'hC0DE};
    endfunction
    function automatic logic [31:0] mem_val(input logic [4:0] a);
        return {8'h22, 3'b000, a, 8'h5A, ~a, 3'b111};
    endfunction

    assign i_pc  = PC_VAL;
    assign i_reg = reg_val(o_debug_addr);
    assign i_mem = mem_val(o_debug_addr);

    int n_checks = 0;
    int n_fail   = 0;

    // Written only by the stimulus process
    int tx_delay = 0;
    int halt_at  = 1 << 30;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
    logic [31:0] exp_cyc;
`endif
    logic [7:0]  exp_q[$];

    // Written only by the monitor process
    int          en_cnt     = 0;
    int          start_viol = 0;
    int          data_viol  = 0;
    logic [31:0] wr_words[$];
    logic [7:0]  rx_bytes[$];
    bit          tx_busy    = 1'b0;
    int          tx_cnt     = 0;
    logic [7:0]  tx_held    = 8'h00;

    // Monitor: counts enable cycles, drives halt, records writes, acts as UART tx
    initial begin
        i_tx_done = 1'b0;
        i_halt    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_tx_done = 1'b0;
            if (o_enable) en_cnt++;
            i_halt = (en_cnt >= halt_at);
            if (o_write) wr_words.push_back(o_instruction);
            if (tx_busy) begin
                if (o_tx_start) start_viol++;
                if (o_tx_data !== tx_held) data_viol++;
                if (tx_cnt == 0) begin
                    i_tx_done = 1'b1;
                    tx_busy   = 1'b0;
                end else begin
                    tx_cnt--;
                end
            end else if (o_tx_start) begin
                rx_bytes.push_back(o_tx_data);
                tx_held = o_tx_data;
                tx_busy = 1'b1;
                tx_cnt  = tx_delay;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (o_busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        ok = !o_busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic build_expected();
        logic [31:0] w;
        exp_q.delete();
        for (int k = 0; k < 65; k++) begin
            if (k == 0)       w = PC_VAL;
            else if (k <= 32) w = reg_val(5'(k - 1));
            else              w = mem_val(5'(k - 33));
            for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
        end
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
        for (int b = 0; b < 4; b++) exp_q.push_back(exp_cyc[31-8*b -: 8]);
`endif
    endtask

    function automatic int first_mismatch(input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= rx_bytes.size()) return i;
            if (rx_bytes[base + i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rx_word(input int idx);
        if (idx + 3 >= rx_bytes.size()) return 32'hXXXX_XXXX;
        return {rx_bytes[idx], rx_bytes[idx+1], rx_bytes[idx+2], rx_bytes[idx+3]};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_write, o_enable, o_busy, o_tx_start} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000", {o_write, o_enable, o_busy, o_tx_start});
        end
        i_reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_instruction, o_debug_addr, o_tx_data} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_data: instr=%h addr=%h tx=%h expected all 0", o_instruction, o_debug_addr, o_tx_data);
        end
    endtask

    task automatic test_reset_mid_load();
        int wb;
        do_reset();
        wb = wr_words.size();
        send_byte(8'h4C);
        send_byte(8'h20);
        send_byte(8'h02);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load_busy: got %b expected 1", o_busy);
        end
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_load_reset: busy/write got %b expected 00", {o_busy, o_write});
        end
        send_byte(8'h4C);
        send_word(32'h2002_0002);
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_words.size() - wb !== 1) begin
            n_fail++;
            $display("FAIL mid_load_writes: got %0d expected 1", wr_words.size() - wb);
        end else begin
            n_checks++;
            if (wr_words[wb] !== 32'h2002_0002) begin
                n_fail++;
                $display("FAIL mid_load_word: got %h expected 20020002", wr_words[wb]);
            end
        end
    endtask

    task automatic test_load();
        int wb;
        logic [31:0] words [3];
        words[0] = 32'h2002_0002;
        words[1] = 32'h0002_5021;
        words[2] = 32'h0000_003F;
        do_reset();
        wb = wr_words.size();
        send_byte(8'h4C);
        for (int i = 0; i < 3; i++) send_word(words[i]);
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_words.size() - wb !== 3) begin
            n_fail++;
            $display("FAIL load_writes: got %0d expected 3", wr_words.size() - wb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_words[wb+i] !== words[i]) begin
                    n_fail++;
                    $display("FAIL load_word%0d: got %h expected %h", i, wr_words[wb+i], words[i]);
                end
            end
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_end_idle: busy got %b expected 0", o_busy);
        end
        // Stray bytes after HALT, then an unknown command, must all be ignored
        send_byte(8'h00);
        send_word(32'h2002_0002);
        send_byte(8'h41);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_busy, o_enable} !== 2'b00 || wr_words.size() - wb !== 3) begin
            n_fail++;
            $display("FAIL load_ignore: busy/enable %b writes %0d expected 00 and 3", {o_busy, o_enable}, wr_words.size() - wb);
        end
        n_checks++;
        if (o_instruction !== 32'h0000_003F) begin
            n_fail++;
            $display("FAIL load_hold: instr got %h expected 0000003f", o_instruction);
        end
    endtask

    task automatic test_run(input string name, input int halt_after, input logic [7:0] cmd,
                            input int exp_en, input int delay, input int budget);
        int  eb, rb, sb, db, mm;
        bit  ok;
        do_reset();
        tx_delay = delay;
        eb = en_cnt;
        rb = rx_bytes.size();
        sb = start_viol;
        db = data_viol;
        halt_at = eb + halt_after;
        repeat (2) @(negedge clk);
        send_byte(cmd);
        wait_idle(budget, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
        end
        n_checks++;
        if (en_cnt - eb !== exp_en) begin
            n_fail++;
            $display("FAIL %s_enable_cycles: got %0d expected %0d", name, en_cnt - eb, exp_en);
        end
        n_checks++;
        if (rx_bytes.size() - rb !== DUMP_BYTES) begin
            n_fail++;
            $display("FAIL %s_byte_count: got %0d expected %0d", name, rx_bytes.size() - rb, DUMP_BYTES);
        end
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
        exp_cyc = 32'(exp_en);
`endif
        build_expected();
        mm = first_mismatch(rb);
        n_checks++;
        if (mm != -1) begin
            n_fail++;
            $display("FAIL %s_dump: first bad byte %0d got %h expected %h", name, mm,
                     (rb + mm < rx_bytes.size()) ? rx_bytes[rb+mm] : 8'hxx, exp_q[mm]);
        end
        n_checks++;
        if (rx_word(rb + 44) !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL %s_reg10: got %h expected 00000002", name, rx_word(rb + 44));
        end
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
        n_checks++;
        if (rx_word(rb + 260) !== 32'(exp_en)) begin
            n_fail++;
            $display("FAIL %s_cycle_count: got %h expected %h", name, rx_word(rb + 260), 32'(exp_en));
        end
`endif
        n_checks++;
        if (start_viol - sb !== 0 || data_viol - db !== 0) begin
            n_fail++;
            $display("FAIL %s_handshake: early starts %0d, data changes %0d, expected 0 and 0", name, start_viol - sb, data_viol - db);
        end
        tx_delay = 0;
    endtask

    initial begin
        i_reset    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        test_reset();
        test_reset_mid_load();
        test_load();
        test_run("run",           7, 8'h52, 7, 0,  6000);
        test_run("run_halted",    0, 8'h52, 1, 0,  6000);
        test_run("step",          7, 8'h53, 1, 0,  6000);
        test_run("step_slow_tx",  7, 8'h53, 1, 50, 20000);
        test_run("run_slow_tx",   7, 8'h52, 7, 50, 20000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
